bch_poly_divider: RTL and testbench
===================================

Name: bch_poly_divider

Overview:
- Parametrised serial GF(2) polynomial divider. It is the shared engine for the BCH encoder and the BCH decoder front end.
- Encode mode: takes a K_W-bit message and produces the systematic N_W-bit codeword {msg, parity}.
- Check mode: takes an N_W-bit received word and produces its remainder modulo the generator, plus an error flag.
- Sits between the 16-bit data link and the BCH_decoder error-locator stage. Uses valid/ready handshakes on both sides.

Parameters:
- N_W, 31, codeword length in bits.
- K_W, 16, message length in bits. R = N_W-K_W is the parity width, 15 by default.
- GEN_POLY, 16'h8FAF, generator polynomial, R+1 bits, MSB is x^R. Default is BCH(31,16,t=3): x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- RESET, input, 1, synchronous, active-high reset.
- in_valid, input, 1, source has a job.
- in_ready, output, 1, block can accept a job.
- in_mode, input, 1, 0 = encode, 1 = check. Sampled at accept.
- in_data, input, N_W, check: full received word. Encode: message in [K_W-1:0], upper bits ignored.
- out_valid, output, 1, result available.
- out_ready, input, 1, sink accepts result.
- out_data, output, N_W, encode: {msg, rem}. Check: received word passed through unchanged.
- out_rem, output, R, remainder of the dividend mod GEN_POLY.
- out_err, output, 1, check mode: 1 when out_rem != 0. Encode mode: always 0.

Behaviour:
- Reset: RESET high at a clock edge forces state IDLE on that edge.
  - in_ready=1, out_valid=0, out_data=0, out_rem=0, out_err=0.
  - Internal shift register, remainder and counter cleared.
  - Reset mid-SHIFT or mid-DONE aborts the job; no result is emitted.
- Elaboration check: GEN_POLY[R]==1, GEN_POLY[0]==1 and K_W<N_W, otherwise $fatal.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Latch mode.
  - Load dividend register D (N_W bits): check mode D=in_data; encode mode D={in_data[K_W-1:0], R'b0}.
  - rem<=0, cnt<=N_W-1, go to SHIFT.
- SHIFT: in_ready=0. One dividend bit per cycle, MSB first.
  - b=D[N_W-1]; D<=D<<1.
  - rem <= {rem[R-2:0], b} ^ (rem[R-1] ? GEN_POLY[R-1:0] : 0).
  - Exactly N_W SHIFT cycles. On cnt==0, go to DONE and register the outputs (out_rem, out_data, out_err) on that same edge.
- DONE: out_valid=1. Outputs stay stable until out_ready is high at an edge, then go to IDLE with out_valid=0.
  - out_data and out_rem hold their last values after the handshake.
- Latency: accept at edge 0; out_valid is high from edge N_W+1. Minimum job period is N_W+2 cycles.
- in_ready is never high while out_valid is high; no accept in DONE.
- in_data, in_mode and in_valid are ignored outside IDLE.
- Arithmetic: all XOR, no carries. The remainder is strictly R bits.
- Encode out_data = {msg, rem}. This codeword is always divisible by GEN_POLY.
- Widths: nothing is hard-coded to 31/16/15. All are derived from N_W, K_W and GEN_POLY. The counter width is $clog2(N_W).

Test Plan:
- Encode, in_data=16'h0001, out_ready=1 -> after 32 cycles: out_data=31'h00008FAF, out_rem=15'h0FAF, out_err=0.
- Check, in_data=31'h00008FAF -> out_rem=0, out_err=0, out_data=31'h00008FAF.
- Check, single-bit error in_data=31'h00008FAE -> out_rem=15'h0001, out_err=1.
- Round-trip: 200 random 16-bit messages are encoded, each result fed to check mode -> every out_rem=0. Each result with one random bit flipped -> every out_err=1.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_valid, out_data and out_rem stable; in_ready=0 throughout; job taken in the cycle after out_ready=1.
- Reset on SHIFT cycle 7 -> next cycle in_ready=1, out_valid=0, all outputs 0. A following encode of 16'h0000 -> out_data=0, out_rem=0.

Source files
------------

// File: rtl/bch_poly_divider.sv
// Serial GF(2) polynomial divider shared by the BCH encoder and the BCH
// decoder front end. Encode mode appends the parity remainder to a message;
// check mode reports the syndrome-style remainder of a received word.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, holds with stable payload until that edge.
module bch_poly_divider #(
  parameter int N_W = 31,
  parameter int K_W = 16,
  parameter logic [N_W-K_W:0] GEN_POLY = 16'h8FAF
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [N_W-1:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_W-1:0]     out_data,
  output logic [N_W-K_W-1:0] out_rem,
  output logic               out_err,
  output logic [1:0]         state_dbg
);

  localparam int R  = N_W - K_W;
  localparam int CW = $clog2(N_W);

  // Reject generators that are not a true degree-R polynomial with a
  // constant term; such a divisor would not yield a usable cyclic code.
  if (GEN_POLY[R] != 1'b1 || GEN_POLY[0] != 1'b1 || K_W >= N_W) begin : g_param_check
    $fatal(1, "bch_poly_divider: invalid N_W/K_W/GEN_POLY combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic           mode;
  logic [N_W-1:0] d_reg;
  logic [R-1:0]   rem;
  logic [CW-1:0]  cnt;

  logic           b;
  logic [N_W-1:0] d_rot;
  logic [R:0]     rem_sh;
  logic [R-1:0]   rem_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

  // One division step: bring in the next dividend bit and fold the x^R
  // overflow term back in with the low part of the generator. The dividend
  // is rotated rather than shifted so that after N_W steps it is intact
  // again and can be passed through as out_data without a second copy.
  always_comb begin
    b        = d_reg[N_W-1];
    d_rot    = {d_reg[N_W-2:0], b};
    rem_sh   = {rem, b};
    rem_next = rem_sh[R-1:0] ^ (rem[R-1] ? GEN_POLY[R-1:0] : {R{1'b0}});
  end

  // Job control: accept in IDLE, N_W shift steps, then hold the result
  // until the sink takes it.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= IDLE;
      mode     <= 1'b0;
      d_reg    <= '0;
      rem      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_rem  <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode  <= in_mode;
            d_reg <= in_mode ? in_data : {in_data[K_W-1:0], {R{1'b0}}};
            rem   <= '0;
            cnt   <= CW'(N_W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          d_reg <= d_rot;
          rem   <= rem_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            out_rem  <= rem_next;
            out_data <= mode ? d_rot : {d_rot[N_W-1:R], rem_next};
            out_err  <= mode & (|rem_next);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_poly_divider.sv
// Bench for bch_poly_divider: directed vectors plus an encode/check
// round trip, with a queue-based scoreboard fed at accept time and drained
// by an independent output monitor.
module tb_bch_poly_divider;

  localparam int N_W = 31;
  localparam int K_W = 16;
  localparam int R   = N_W - K_W;
  localparam logic [R:0] GEN_POLY = 16'h8FAF;
  localparam int W   = N_W + R + 1;

  logic           clk;
  logic           RESET;
  logic           in_valid;
  logic           in_ready;
  logic           in_mode;
  logic [N_W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] out_data;
  logic [R-1:0]   out_rem;
  logic           out_err;
  logic [1:0]     state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  bch_poly_divider #(.N_W(N_W), .K_W(K_W), .GEN_POLY(GEN_POLY)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rem   (out_rem),
    .out_err   (out_err),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [N_W-1:0] act,
                       input logic [N_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference remainder by schoolbook long division on the whole word.
  function automatic logic [R-1:0] mod_g(input logic [N_W-1:0] w);
    logic [N_W-1:0] g;
    logic [N_W-1:0] t;
    g = N_W'(GEN_POLY);
    t = w;
    for (int i = N_W - 1; i >= R; i--) begin
      if (t[i]) t = t ^ (g << (i - R));
    end
    return t[R-1:0];
  endfunction

  // Driver: present a job, wait for acceptance, optionally record expectation.
  task automatic send_job(input logic mode, input logic [N_W-1:0] data,
                          input logic [N_W-1:0] e_data, input logic [R-1:0] e_rem,
                          input logic e_err, input logic do_push);
    logic accepted;
    accepted = 1'b0;
    in_mode  = mode;
    in_data  = data;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end else if (do_push) begin
      exp_q.push_back({e_data, e_rem, e_err});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic mode, input logic [N_W-1:0] data);
    logic [N_W-1:0] cw;
    logic [R-1:0]   r;
    if (mode) begin
      r = mod_g(data);
      send_job(1'b1, data, data, r, |r, 1'b1);
    end else begin
      cw = {data[K_W-1:0], {R{1'b0}}};
      r  = mod_g(cw);
      send_job(1'b0, data, cw | N_W'(r), r, 1'b0, 1'b1);
    end
  endtask

  task automatic drain();
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    if (!empty) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each result on the cycle its handshake is about to occur.
  always @(negedge clk) begin
    if (!RESET && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=data_%h required=no_output", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e[W-1 -: N_W]);
        check("out_rem", N_W'(out_rem), N_W'(e[R:1]));
        check("out_err", N_W'(out_err), N_W'(e[0]));
      end
    end
  end

  // Stimulus
  initial begin
    logic [N_W-1:0] cw;
    logic [N_W-1:0] cwf;
    logic [R-1:0]   r;
    logic [K_W-1:0] msg;
    int             bit_i;
    logic           seen;

    RESET     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;

    check("reset_in_ready", N_W'(in_ready), N_W'(1'b1));
    check("reset_out_valid", N_W'(out_valid), '0);
    check("reset_out_data", out_data, '0);
    check("reset_out_rem", N_W'(out_rem), '0);
    check("reset_out_err", N_W'(out_err), '0);

    // Directed, hand-computed vectors
    send_job(1'b0, 31'h0000_0001, 31'h0000_8FAF, 15'h0FAF, 1'b0, 1'b1);
    send_job(1'b1, 31'h0000_8FAF, 31'h0000_8FAF, 15'h0000, 1'b0, 1'b1);
    send_job(1'b1, 31'h0000_8FAE, 31'h0000_8FAE, 15'h0001, 1'b1, 1'b1);
    // Upper bits of in_data are ignored in encode mode
    send_job(1'b0, 31'h7FFF_0001, 31'h0000_8FAF, 15'h0FAF, 1'b0, 1'b1);
    // All-zero check word and a codeword with only the top bit flipped
    send_job(1'b1, 31'h0000_0000, 31'h0000_0000, 15'h0000, 1'b0, 1'b1);
    send_model(1'b1, 31'h4000_8FAF);
    send_model(1'b0, 31'h0000_FFFF);
    send_model(1'b0, 31'h0000_8000);
    drain();

    // Round trip: encode, check clean codeword, check with one bit flipped
    for (int n = 0; n < 200; n++) begin
      msg   = K_W'($urandom_range(0, 65535));
      cw    = {msg, {R{1'b0}}};
      cw    = cw | N_W'(mod_g(cw));
      bit_i = $urandom_range(0, N_W - 1);
      cwf   = cw;
      cwf[bit_i] = ~cwf[bit_i];
      r     = mod_g(cwf);
      send_job(1'b0, N_W'(msg), cw, mod_g({msg, {R{1'b0}}}), 1'b0, 1'b1);
      send_job(1'b1, cw, cw, '0, 1'b0, 1'b1);
      send_job(1'b1, cwf, cwf, r, 1'b1, 1'b1);
    end
    drain();

    // Backpressure: hold the result for 10 cycles
    out_ready = 1'b0;
    send_job(1'b0, 31'h0000_0001, 31'h0000_8FAF, 15'h0FAF, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", N_W'(seen), N_W'(1'b1));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", N_W'(out_valid), N_W'(1'b1));
      check("bp_out_data", out_data, 31'h0000_8FAF);
      check("bp_out_rem", N_W'(out_rem), N_W'(15'h0FAF));
      check("bp_in_ready", N_W'(in_ready), '0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_in_ready", N_W'(in_ready), N_W'(1'b1));
    check("bp_after_out_valid", N_W'(out_valid), '0);
    check("bp_hold_out_data", out_data, 31'h0000_8FAF);
    check("bp_hold_out_rem", N_W'(out_rem), N_W'(15'h0FAF));
    send_job(1'b1, 31'h0000_8FAE, 31'h0000_8FAE, 15'h0001, 1'b1, 1'b1);
    drain();

    // Reset on the seventh shift cycle aborts the job
    send_job(1'b0, 31'h0000_1234, '0, '0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    check("abort_in_ready", N_W'(in_ready), N_W'(1'b1));
    check("abort_out_valid", N_W'(out_valid), '0);
    check("abort_out_data", out_data, '0);
    check("abort_out_rem", N_W'(out_rem), '0);
    check("abort_out_err", N_W'(out_err), '0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_result", N_W'(out_valid), '0);
    send_job(1'b0, 31'h0000_0000, 31'h0000_0000, 15'h0000, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
